// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INST      : canonical bubble instruction (addi x0, x0, 0)
//   PC_INC        : sequential fetch stride in bytes
//   fetch_state_e : fetch controller states
//   if_id_t       : one IF/ID pipeline-register record
package if_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  // IDLE: no request; BUSY: request live, result wanted;
  // DROP: request live, result discarded; HOLD: result parked in skid buffer.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DROP,
    ST_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_stall      : hold current contents
//   i_flush      : load a bubble (wins over stall and load)
//   i_load       : an instruction is delivered this cycle (i_pc, i_inst)
//   o_pc, o_inst, o_valid : registered IF/ID contents
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid
);

  if_id_t q;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      q <= IF_ID_BUBBLE;
    end else if (!i_stall) begin
      // Not stalled: take the delivered instruction, or a bubble if none.
      q <= i_load ? '{pc: i_pc, inst: i_inst, valid: 1'b1} : IF_ID_BUBBLE;
    end
  end

  assign o_pc    = q.pc;
  assign o_inst  = q.inst;
  assign o_valid = q.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request controller,
// one-entry skid buffer and IF/ID register.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_stall_pc          : freeze fetch / do not advance; blocks redirects
//   i_stall_if_id       : hold IF/ID contents
//   i_flush_if_id       : replace IF/ID contents with a bubble
//   i_flush_mux_pc      : redirect fetch to i_pc_target
//   o_imem_req/addr     : registered instruction-memory request
//   i_imem_ack/rdata    : request completion and fetched instruction
//   o_ID_pc/inst/valid  : IF/ID register outputs
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall_pc,
  input  logic        i_stall_if_id,
  input  logic        i_flush_if_id,
  input  logic        i_flush_mux_pc,
  input  logic [31:0] i_pc_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_ID_pc,
  output logic [31:0] o_ID_inst,
  output logic        o_ID_valid
);

  fetch_state_e state_q, state_d;
  logic         req_q, req_d;
  logic [31:0]  pc_q, pc_d;           // address of the live/next request
  logic [31:0]  target_q, target_d;   // redirect target held while in DROP
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  skid_inst_q, skid_inst_d;

  logic         load;
  logic [31:0]  load_pc;
  logic [31:0]  load_inst;

  logic         redirect;
  logic [31:0]  target;
  logic         ack;
  logic         stall;

  assign redirect = i_flush_mux_pc && !i_stall_pc;
  assign target   = align_word(i_pc_target);
  // Acks only count while a request is actually live.
  assign ack      = i_imem_ack && req_q;
  assign stall    = i_stall_pc || i_stall_if_id;

  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    pc_d        = pc_q;
    target_d    = target_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    load        = 1'b0;
    load_pc     = pc_q;
    load_inst   = i_imem_rdata;

    case (state_q)
      ST_IDLE: begin
        req_d   = 1'b1;
        state_d = ST_BUSY;
      end

      ST_BUSY: begin
        if (redirect) begin
          if (ack) begin
            pc_d = target;              // returning data is stale; refetch now
          end else begin
            target_d = target;          // address must stay stable until ack
            state_d  = ST_DROP;
          end
        end else if (ack) begin
          if (stall) begin
            skid_pc_d   = pc_q;
            skid_inst_d = i_imem_rdata;
            req_d       = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            load = 1'b1;
            pc_d = pc_q + PC_INC;
          end
        end
      end

      ST_DROP: begin
        if (ack) begin
          pc_d    = redirect ? target : target_q;
          state_d = ST_BUSY;
        end else if (redirect) begin
          target_d = target;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          req_d   = 1'b1;
          state_d = ST_BUSY;
        end else if (!stall) begin
          load      = 1'b1;
          load_pc   = skid_pc_q;
          load_inst = skid_inst_q;
          pc_d      = skid_pc_q + PC_INC;
          req_d     = 1'b1;
          state_d   = ST_BUSY;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      pc_q        <= RESET_PC;
      target_q    <= 32'h0;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  assign o_imem_req  = req_q;
  assign o_imem_addr = pc_q;

  if_id_reg u_if_id_reg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_stall (i_stall_if_id),
    .i_flush (i_flush_if_id),
    .i_load  (load),
    .i_pc    (load_pc),
    .i_inst  (load_inst),
    .o_pc    (o_ID_pc),
    .o_inst  (o_ID_inst),
    .o_valid (o_ID_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a directed vector table on a RESET_PC=0
// instance, plus a hand-written wrap/reset sequence on a RESET_PC=0xFFFFFFFC
// instance.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Instance 0 stimulus
  logic        rst, stall_pc, stall_if_id, flush_if_id, flush_mux_pc, ack;
  logic [31:0] pc_target, rdata;
  logic        imem_req;
  logic [31:0] imem_addr, id_pc, id_inst;
  logic        id_valid;

  // Instance 1 stimulus
  logic        rst1, ack1;
  logic [31:0] rdata1;
  logic        tie0 = 1'b0;
  logic [31:0] tie0_32 = 32'h0;
  logic        imem_req1;
  logic [31:0] imem_addr1, id_pc1, id_inst1;
  logic        id_valid1;

  if_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .i_clk          (i_clk),
    .i_rst          (rst),
    .i_stall_pc     (stall_pc),
    .i_stall_if_id  (stall_if_id),
    .i_flush_if_id  (flush_if_id),
    .i_flush_mux_pc (flush_mux_pc),
    .i_pc_target    (pc_target),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_ack     (ack),
    .i_imem_rdata   (rdata),
    .o_ID_pc        (id_pc),
    .o_ID_inst      (id_inst),
    .o_ID_valid     (id_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .i_clk          (i_clk),
    .i_rst          (rst1),
    .i_stall_pc     (tie0),
    .i_stall_if_id  (tie0),
    .i_flush_if_id  (tie0),
    .i_flush_mux_pc (tie0),
    .i_pc_target    (tie0_32),
    .o_imem_req     (imem_req1),
    .o_imem_addr    (imem_addr1),
    .i_imem_ack     (ack1),
    .i_imem_rdata   (rdata1),
    .o_ID_pc        (id_pc1),
    .o_ID_inst      (id_inst1),
    .o_ID_valid     (id_valid1)
  );

  typedef struct {
    logic        rst, spc, sif, fif, fmux;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [step %0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic spc, input logic sif, input logic fif,
                     input logic fmux, input logic [31:0] tgt, input logic a,
                     input logic [31:0] d, input logic ereq, input logic [31:0] eaddr,
                     input logic ev, input logic [31:0] epc, input logic [31:0] einst);
    vec_t v;
    v.rst = r; v.spc = spc; v.sif = sif; v.fif = fif; v.fmux = fmux;
    v.tgt = tgt; v.ack = a; v.rdata = d;
    v.exp_req = ereq; v.exp_addr = eaddr;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_inst = einst;
    vecs.push_back(v);
  endtask

  task automatic step1(input logic r, input logic a, input logic [31:0] d);
    rst1 = r; ack1 = a; rdata1 = d;
    @(posedge i_clk); #1;
  endtask

  task automatic check1(input int idx, input logic ereq, input logic [31:0] eaddr,
                        input logic ev, input logic [31:0] epc, input logic [31:0] einst);
    check("wrap.req",   idx, {31'h0, imem_req1}, {31'h0, ereq});
    check("wrap.addr",  idx, imem_addr1, eaddr);
    check("wrap.valid", idx, {31'h0, id_valid1}, {31'h0, ev});
    check("wrap.pc",    idx, id_pc1, epc);
    check("wrap.inst",  idx, id_inst1, einst);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall_pc = 0; stall_if_id = 0; flush_if_id = 0; flush_mux_pc = 0;
    pc_target = 0; ack = 0; rdata = 0;
    rst1 = 1'b1; ack1 = 0; rdata1 = 0;

    //  rst spc sif fif fmux tgt      ack rdata            req addr        v pc      inst
    // reset, stray ack ignored, streaming 0,4,8
    add(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,          0, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'hFFFF_0000,  1, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'h1111_0000,  1, 32'h4,   1, 32'h0,   32'h1111_0000);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'h2222_0004,  1, 32'h8,   1, 32'h4,   32'h2222_0004);
    // ack for 0x8 under IF/ID stall for 3 cycles -> skid, then release
    add(0, 0, 1, 0, 0, 32'h0,   1, 32'h3333_0008,  0, 32'h8,   1, 32'h4,   32'h2222_0004);
    add(0, 0, 1, 0, 0, 32'h0,   1, 32'hBAD0_0001,  0, 32'h8,   1, 32'h4,   32'h2222_0004);
    add(0, 0, 1, 0, 0, 32'h0,   0, 32'h0,          0, 32'h8,   1, 32'h4,   32'h2222_0004);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0,          1, 32'hC,   1, 32'h8,   32'h3333_0008);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0,          1, 32'hC,   0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'h4444_000C,  1, 32'h10,  1, 32'hC,   32'h4444_000C);
    // redirect to 0x103 with 0x10 pending; ack two cycles later is dropped
    add(0, 0, 0, 0, 1, 32'h103, 0, 32'h0,          1, 32'h10,  0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0,          1, 32'h10,  0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'hDEAD_0010,  1, 32'h100, 0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'h5555_0100,  1, 32'h104, 1, 32'h100, 32'h5555_0100);
    // second redirect in DROP overwrites stored target
    add(0, 0, 0, 0, 1, 32'h200, 0, 32'h0,          1, 32'h104, 0, 32'h0,   NOP);
    add(0, 0, 0, 0, 1, 32'h20,  0, 32'h0,          1, 32'h104, 0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'hBAD0_0104,  1, 32'h20,  0, 32'h0,   NOP);
    // redirect + ack same cycle at 0x20 -> 0x40
    add(0, 0, 0, 0, 1, 32'h40,  1, 32'hBAD0_0020,  1, 32'h40,  0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'h6666_0040,  1, 32'h44,  1, 32'h40,  32'h6666_0040);
    // same with IF/ID flush, then flush beating a delivery
    add(0, 0, 0, 1, 1, 32'h80,  1, 32'hBAD0_0044,  1, 32'h80,  0, 32'h0,   NOP);
    add(0, 0, 0, 1, 0, 32'h0,   1, 32'h7777_0080,  1, 32'h84,  0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'h8888_0084,  1, 32'h88,  1, 32'h84,  32'h8888_0084);
    // flush beats IF/ID stall
    add(0, 0, 1, 1, 0, 32'h0,   0, 32'h0,          1, 32'h88,  0, 32'h0,   NOP);
    // redirect blocked by stall_pc; sequential fetch resumes at 0x8C
    add(0, 1, 0, 0, 1, 32'h400, 0, 32'h0,          1, 32'h88,  0, 32'h0,   NOP);
    add(0, 1, 0, 0, 1, 32'h400, 1, 32'h9999_0088,  0, 32'h88,  0, 32'h0,   NOP);
    add(0, 1, 0, 0, 1, 32'h400, 0, 32'h0,          0, 32'h88,  0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0,          1, 32'h8C,  1, 32'h88,  32'h9999_0088);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'hAAAA_008C,  1, 32'h90,  1, 32'h8C,  32'hAAAA_008C);
    // redirect while in HOLD discards the buffer
    add(0, 0, 1, 0, 0, 32'h0,   1, 32'hBBBB_0090,  0, 32'h90,  1, 32'h8C,  32'hAAAA_008C);
    add(0, 0, 1, 0, 1, 32'h203, 0, 32'h0,          1, 32'h200, 1, 32'h8C,  32'hAAAA_008C);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'hCCCC_0200,  1, 32'h204, 1, 32'h200, 32'hCCCC_0200);
    // reset with a request pending; stray ack after reset ignored
    add(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,          0, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'hBAD0_DEAD,  1, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 0, 0, 0, 32'h0,   1, 32'hEEEE_0000,  1, 32'h4,   1, 32'h0,   32'hEEEE_0000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; stall_pc = vecs[i].spc; stall_if_id = vecs[i].sif;
      flush_if_id = vecs[i].fif; flush_mux_pc = vecs[i].fmux;
      pc_target = vecs[i].tgt; ack = vecs[i].ack; rdata = vecs[i].rdata;
      @(posedge i_clk); #1;
      check("req",   i, {31'h0, imem_req}, {31'h0, vecs[i].exp_req});
      check("addr",  i, imem_addr, vecs[i].exp_addr);
      check("valid", i, {31'h0, id_valid}, {31'h0, vecs[i].exp_valid});
      check("pc",    i, id_pc, vecs[i].exp_pc);
      check("inst",  i, id_inst, vecs[i].exp_inst);
    end
    rst = 1'b0; ack = 1'b0; flush_mux_pc = 1'b0;

    // RESET_PC = 0xFFFFFFFC: wrap, reset mid-request, stray ack after reset
    step1(1, 0, 32'h0);
    check1(0, 0, 32'hFFFF_FFFC, 0, 32'h0, NOP);
    step1(0, 0, 32'h0);
    check1(1, 1, 32'hFFFF_FFFC, 0, 32'h0, NOP);
    step1(0, 1, 32'h1234_5678);
    check1(2, 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h1234_5678);
    step1(0, 0, 32'h0);
    check1(3, 1, 32'h0, 0, 32'h0, NOP);
    step1(1, 0, 32'h0);
    check1(4, 0, 32'hFFFF_FFFC, 0, 32'h0, NOP);
    step1(0, 1, 32'hDEAD_BEEF);
    check1(5, 1, 32'hFFFF_FFFC, 0, 32'h0, NOP);
    step1(0, 1, 32'hCAFE_0001);
    check1(6, 1, 32'h0, 1, 32'hFFFF_FFFC, 32'hCAFE_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_stall_pc  in  1  freeze fetch address / do not advance.
REQ-005 i_stall_if_id  in  1  hold IF/ID register contents.
REQ-006 i_flush_if_id  in  1  replace IF/ID contents with bubble.
REQ-007 i_flush_mux_pc  in  1  redirect fetch to i_pc_target (taken branch/jump in EX).
REQ-008 i_pc_target  in  32  redirect address from EX.
REQ-009 o_imem_req  out  1  instruction-memory request, registered.
REQ-010 o_imem_addr  out  32  request address, registered, word aligned.
REQ-011 i_imem_ack  in  1  request complete; i_imem_rdata valid this cycle.
REQ-012 i_imem_rdata  in  32  fetched instruction.
REQ-013 o_ID_pc  out  32  IF/ID register: PC of o_ID_inst.
REQ-014 o_ID_inst  out  32  IF/ID register: instruction or NOP.
REQ-015 o_ID_valid  out  1  IF/ID register: instruction is real (0 = bubble).

Function
REQ-016 Exactly one outstanding imem request; o_imem_addr SHALL be stable from req assertion until the ack cycle; acks while o_imem_req=0 SHALL be ignored.
REQ-017 FSM states: IDLE (no request), BUSY (request live, result wanted), DROP (request live, result discarded), HOLD (result in 1-entry skid buffer, no request).
REQ-018 IDLE: entered only from reset; next cycle -> BUSY with o_imem_addr=pc.
REQ-019 BUSY, ack, no redirect, IF/ID accepting (i_stall_pc=0, i_stall_if_id=0): IF/ID <= {addr, rdata, valid=1}; next request at addr+4 on the following cycle; stay BUSY (sustained 1 instr/cycle when ack every cycle).
REQ-020 BUSY, ack, stall active: capture {addr, rdata} in skid buffer; deassert o_imem_req; -> HOLD.
REQ-021 HOLD, stall released: buffer -> IF/ID (valid=1); next request at buffered addr+4; -> BUSY.
REQ-022 Redirect is accepted only when i_flush_mux_pc=1 and i_stall_pc=0; target = {i_pc_target[31:2], 2'b00}.
REQ-023 Redirect in BUSY without ack: store target; -> DROP. Redirect in BUSY with ack: discard rdata; next request at target; stay BUSY.
REQ-024 DROP: ack -> discard rdata, next request at stored target, -> BUSY; further redirect in DROP overwrites stored target.
REQ-025 Redirect in HOLD: discard buffer; next request at target; -> BUSY.
REQ-026 i_flush_if_id=1: IF/ID <= {pc=0, inst=32'h0000_0013, valid=0}; overrides i_stall_if_id and any same-cycle write.
REQ-027 IF/ID not stalled and no instruction delivered this cycle: IF/ID <= bubble (as REQ-026).
REQ-028 i_stall_if_id=1 without flush: IF/ID holds value unchanged.
REQ-029 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.

Reset
REQ-030 On i_rst=1 at a clock edge: state=IDLE, pc=RESET_PC, o_imem_req=0, o_imem_addr=RESET_PC, o_ID_pc=0, o_ID_inst=32'h0000_0013, o_ID_valid=0, skid buffer empty.
REQ-031 Reset mid-request abandons the outstanding request; an ack arriving in the cycle after reset SHALL be ignored.

Structure
REQ-032 Shared package SHALL hold: NOP constant 32'h0000_0013, FSM state enum, PC increment constant 4.
REQ-033 IF/ID register (stall/flush/bubble logic, REQ-026..028) SHALL be a sub-module if_id_reg; FSM, PC and skid buffer stay in if_stage.

Verification
REQ-034 Reset, ack every cycle, no stalls -> o_imem_addr 0x0,0x4,0x8 on consecutive cycles; o_ID_pc follows one cycle after each ack, o_ID_valid=1.
REQ-035 Ack for 0x8 while i_stall_if_id=1 for 3 cycles -> o_imem_req=0 during stall, IF/ID held; on release IF/ID={0x8,data}, next request 0xC.
REQ-036 Request 0x10 pending, redirect to 0x103 with no ack, ack 2 cycles later -> data for 0x10 never reaches IF/ID; next request 0x100.
REQ-037 Redirect and ack same cycle at addr 0x20, target 0x40 -> rdata discarded, next o_imem_addr=0x40; with i_flush_if_id=1 same cycle -> o_ID_valid=0, o_ID_inst=0x00000013.
REQ-038 i_flush_mux_pc=1 with i_stall_pc=1 -> redirect ignored; fetch resumes sequentially after stall unless flush reasserted.
REQ-039 RESET_PC=0xFFFF_FFFC, ack every cycle -> second request 0x0; i_rst pulsed while request pending -> o_imem_req=0 next cycle, restart at RESET_PC, stray ack ignored.
